term_text_engine: RTL
=====================

Name: term_text_engine

Overview:
- Parametrised successor to the UART-driven text framebuffer.
- Consumes a byte stream (from uart_rx or PS/2) and interprets control characters.
- Maintains a COLS x ROWS character store with true hardware scrolling: a rotating top-row offset plus a single-line clear, replacing the whole-screen clear.
- Exposes a 1-cycle-latency read port for the video/font path, with blinking cursor overlay.

Parameters:
- COLS, 80, characters per row (2..128).
- ROWS, 30, rows on screen (2..64).
- BLINK_BITS, 23, blink counter width; cursor phase toggles when the counter wraps to 0.
- TAB_W, 8, tab stop spacing; power of two.
- BLANK_CHAR, 8'h20, fill character for clears.
- CURSOR_CHAR, 8'h5F, glyph substituted at the cursor during blink-on phase.

Ports:
- clk  input  1  system clock (25 MHz pixel clock domain)
- resetn  input  1  synchronous, active-low reset
- in_data  input  8  incoming character byte
- in_valid  input  1  in_data valid
- in_ready  output  1  engine accepts a byte this cycle; transfer = in_valid & in_ready
- rd_col  input  7  video read column (0..COLS-1)
- rd_row  input  6  video read screen row (0..ROWS-1), logical, i.e. not offset-adjusted
- rd_char  output  8  character at (rd_col, rd_row), registered, 1-cycle latency
- cur_col  output  7  cursor column
- cur_row  output  6  cursor logical row
- busy  output  1  high while clearing (init, line, or screen)

Behaviour:
- Storage: COLS*ROWS x 8 dual-port RAM; one write port and one read port per cycle.
  - Physical row = (logical row + top) mod ROWS; address = phys_row*COLS + col.
  - Read-during-write to the same address returns old data.
- Reset: cur_col=0, cur_row=0, top=0, rd_char=BLANK_CHAR, blink phase off, blink counter=0. FSM enters INIT with busy=1, in_ready=0.
- FSM states:
  - INIT: writes BLANK_CHAR to every address, one per cycle (COLS*ROWS cycles), then goes to IDLE.
  - IDLE: in_ready=1, busy=0.
  - CLR_LINE: writes BLANK_CHAR to COLS cells of one physical row, then returns to IDLE.
  - CLR_SCREEN: identical to INIT, but entered from form feed.
  - in_ready=0 in every state except IDLE.
- Byte interpretation on a transfer in IDLE (single cycle unless noted):
  - 0x20..0x7E: write at cursor; cur_col+1. At cur_col=COLS-1, autowrap applies (see Optional Feature).
  - 0x0D CR: cur_col=0.
  - 0x0A LF: if cur_row<ROWS-1, cur_row+1. Otherwise scroll: top=(top+1) mod ROWS, cur_row stays ROWS-1, enter CLR_LINE on the new bottom physical row (old top).
  - 0x08 BS: cur_col-1 if cur_col>0, else no change. No erase.
  - 0x09 TAB: cur_col = next multiple of TAB_W, saturating at COLS-1.
  - 0x0C FF: cur_col=0, cur_row=0, top=0, enter CLR_SCREEN.
  - All other bytes: consumed and ignored.
- Read path:
  - rd_char is registered from RAM one cycle after rd_col/rd_row are presented.
  - If the registered (rd_col, rd_row) equals (cur_col, cur_row) and blink phase is on, rd_char=CURSOR_CHAR.
  - The cursor is overlay only; it is never written to RAM.
  - rd_char reads BLANK_CHAR for cells already cleared, including during INIT.
- Blink counter free-runs from reset; phase toggles each wrap.
- Reset asserted mid-clear or mid-transfer aborts immediately and restarts INIT next cycle.
- Out-of-range rd_col/rd_row: rd_char=BLANK_CHAR.

Optional Feature:
- Macro: TERM_AUTOWRAP_EN.
- Defined: a printable byte at cur_col=COLS-1 is written, then cur_col=0 and an implicit LF is performed, including scroll + CLR_LINE at the last row.
- Undefined: the byte is written at COLS-1 and the cursor stays at COLS-1; subsequent printables overwrite that cell.

Decomposition:
- Shared package term_pkg:
  - control-code constants (CHAR_CR, CHAR_LF, CHAR_BS, CHAR_TAB, CHAR_FF);
  - FSM state encoding (ST_INIT, ST_IDLE, ST_CLR_LINE, ST_CLR_SCREEN);
  - default BLANK_CHAR/CURSOR_CHAR.
- One sub-module: term_char_ram (simple dual-port, registered read, parametrised depth), so it infers BRAM cleanly.

Test Plan:
- Reset with COLS=80, ROWS=30: busy high for exactly 2400 cycles, in_ready=0 throughout. Afterwards, reading every cell returns 0x20.
- Send "AB" then CR LF "C": rd(0,0)=0x41, rd(1,0)=0x42, rd(0,1)=0x43; cursor ends at (1,1).
- Send 30 LFs from row 0, with "X" written at row 0 beforehand:
  - top=1 and cur_row=29;
  - busy high for 80 cycles after the last LF;
  - logical row 29 reads all 0x20;
  - "X" now appears at logical row -1, i.e. gone, and the former row 1 content is at row 0.
- TAB from col 0 → col 8; TAB from col 78 → col 79; BS at col 0 → col 0.
- 81 printables with TERM_AUTOWRAP_EN: 81st char at (0,1). Without the macro: 81st char overwrites (79,0) and the cursor stays at 79.
- Hold in_valid=1 with 0x0C during CLR_SCREEN: no transfer until busy falls, then exactly one FF is accepted.
- Blink overlay: with BLINK_BITS=4, rd at the cursor alternates 0x5F/underlying char every 16 cycles.

Source files
------------

// File: rtl/term_pkg.sv
// term_pkg: control codes, FSM encoding and default glyphs shared by the terminal text engine.
package term_pkg;
    localparam logic [7:0] CHAR_BS  = 8'h08;
    localparam logic [7:0] CHAR_TAB = 8'h09;
    localparam logic [7:0] CHAR_LF  = 8'h0A;
    localparam logic [7:0] CHAR_FF  = 8'h0C;
    localparam logic [7:0] CHAR_CR  = 8'h0D;
    localparam logic [7:0] DEF_BLANK_CHAR  = 8'h20;
    localparam logic [7:0] DEF_CURSOR_CHAR = 8'h5F;
    typedef enum logic [1:0] {ST_INIT, ST_IDLE, ST_CLR_LINE, ST_CLR_SCREEN} state_e;
endpackage

// File: rtl/term_char_ram.sv
// term_char_ram: simple dual-port character store with registered read (old data on collision).
module term_char_ram #(
    parameter int DEPTH = 2400,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [7:0]    wdata_i,
    input  logic [AW-1:0] raddr_i,
    output logic [7:0]    rdata_o
);
    logic [7:0] mem [DEPTH];
    always_ff @(posedge clk) begin
        if (we_i) mem[waddr_i] <= wdata_i;
        rdata_o <= mem[raddr_i];
    end
endmodule

// File: rtl/term_text_engine.sv
// term_text_engine: byte-stream text terminal with hardware scrolling and blinking cursor overlay.
// Define TERM_AUTOWRAP_EN to wrap printables at the last column with an implicit LF.
module term_text_engine
    import term_pkg::*;
#(
    parameter int         COLS        = 80,
    parameter int         ROWS        = 30,
    parameter int         BLINK_BITS  = 23,
    parameter int         TAB_W       = 8,
    parameter logic [7:0] BLANK_CHAR  = DEF_BLANK_CHAR,
    parameter logic [7:0] CURSOR_CHAR = DEF_CURSOR_CHAR
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic [7:0] in_data,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [6:0] rd_col,
    input  logic [5:0] rd_row,
    output logic [7:0] rd_char,
    output logic [6:0] cur_col,
    output logic [5:0] cur_row,
    output logic       busy
);
    localparam int N  = COLS * ROWS;
    localparam int AW = $clog2(N);
`ifdef TERM_AUTOWRAP_EN
    localparam bit AUTOWRAP = 1'b1;
`else
    localparam bit AUTOWRAP = 1'b0;
`endif

    state_e                state_q;
    logic                  in_ready_q, busy_q, blink_q, rd_ok_q;
    logic [6:0]            cur_col_q, rd_col_q;
    logic [5:0]            cur_row_q, rd_row_q, top_q;
    logic [AW-1:0]         clr_q, clr_base_q;
    logic [BLINK_BITS-1:0] blink_cnt_q;

    logic          xfer, printable, at_last, lf, clearing, rd_ok, we;
    logic [7:0]    tab_col, ram_q, wdata;
    logic [AW-1:0] cur_addr, rd_addr, clr_last, waddr;

    // Logical row to physical row through the rotating top offset.
    function automatic logic [5:0] phys(input logic [5:0] r, input logic [5:0] t);
        logic [6:0] s;
        s = {1'b0, r} + {1'b0, t};
        return (s >= 7'(ROWS)) ? 6'(s - 7'(ROWS)) : s[5:0];
    endfunction

    assign xfer      = in_valid & in_ready_q;
    assign printable = (in_data >= 8'h20) && (in_data <= 8'h7E);
    assign at_last   = cur_col_q == 7'(COLS - 1);
    assign lf        = xfer & ((in_data == CHAR_LF) | (printable & at_last & AUTOWRAP));
    assign tab_col   = ({1'b0, cur_col_q} | 8'(TAB_W - 1)) + 8'd1;
    assign clearing  = state_q != ST_IDLE;
    assign clr_last  = (state_q == ST_CLR_LINE) ? AW'(COLS - 1) : AW'(N - 1);
    assign cur_addr  = AW'(phys(cur_row_q, top_q)) * AW'(COLS) + AW'(cur_col_q);
    assign rd_ok     = ({1'b0, rd_col} < 8'(COLS)) && ({1'b0, rd_row} < 7'(ROWS));
    assign rd_addr   = rd_ok ? AW'(phys(rd_row, top_q)) * AW'(COLS) + AW'(rd_col) : '0;
    assign we        = clearing | (xfer & printable);
    assign waddr     = clearing ? clr_base_q + clr_q : cur_addr;
    assign wdata     = clearing ? BLANK_CHAR : in_data;

    term_char_ram #(.DEPTH(N), .AW(AW)) u_ram (
        .clk     (clk),
        .we_i    (we),
        .waddr_i (waddr),
        .wdata_i (wdata),
        .raddr_i (rd_addr),
        .rdata_o (ram_q)
    );

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q    <= ST_INIT;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b1;
            cur_col_q  <= '0;
            cur_row_q  <= '0;
            top_q      <= '0;
            clr_q      <= '0;
            clr_base_q <= '0;
        end else if (clearing) begin
            clr_q <= clr_q + AW'(1);
            if (clr_q == clr_last) begin
                state_q    <= ST_IDLE;
                in_ready_q <= 1'b1;
                busy_q     <= 1'b0;
                clr_q      <= '0;
            end
        end else if (xfer) begin
            if (printable)
                cur_col_q <= at_last ? (AUTOWRAP ? 7'd0 : cur_col_q) : cur_col_q + 7'd1;
            else if (in_data == CHAR_CR)
                cur_col_q <= 7'd0;
            else if (in_data == CHAR_BS && cur_col_q != 7'd0)
                cur_col_q <= cur_col_q - 7'd1;
            else if (in_data == CHAR_TAB)
                cur_col_q <= (tab_col > 8'(COLS - 1)) ? 7'(COLS - 1) : tab_col[6:0];
            // At the bottom, scroll and blank the old top row, which becomes the new bottom.
            if (lf) begin
                if (cur_row_q != 6'(ROWS - 1)) begin
                    cur_row_q <= cur_row_q + 6'd1;
                end else begin
                    top_q      <= (top_q == 6'(ROWS - 1)) ? 6'd0 : top_q + 6'd1;
                    clr_base_q <= AW'(top_q) * AW'(COLS);
                    state_q    <= ST_CLR_LINE;
                    in_ready_q <= 1'b0;
                    busy_q     <= 1'b1;
                end
            end
            if (in_data == CHAR_FF) begin
                cur_col_q  <= '0;
                cur_row_q  <= '0;
                top_q      <= '0;
                clr_base_q <= '0;
                state_q    <= ST_CLR_SCREEN;
                in_ready_q <= 1'b0;
                busy_q     <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            blink_cnt_q <= '0;
            blink_q     <= 1'b0;
            rd_ok_q     <= 1'b0;
            rd_col_q    <= '0;
            rd_row_q    <= '0;
        end else begin
            blink_cnt_q <= blink_cnt_q + BLINK_BITS'(1);
            if (&blink_cnt_q) blink_q <= ~blink_q;
            rd_ok_q  <= rd_ok;
            rd_col_q <= rd_col;
            rd_row_q <= rd_row;
        end
    end

    assign rd_char  = !rd_ok_q ? BLANK_CHAR :
                      (blink_q && rd_col_q == cur_col_q && rd_row_q == cur_row_q) ? CURSOR_CHAR : ram_q;
    assign in_ready = in_ready_q;
    assign busy     = busy_q;
    assign cur_col  = cur_col_q;
    assign cur_row  = cur_row_q;
endmodule
